// File: rtl/sme_driver.sv
// Streams a string and/or pattern from local buffers to a matcher, then reports the
// matcher result or a timeout. States: IDLE, SEND_STR, SEND_PAT, WAIT, REPORT.
module sme_driver #(
  parameter int TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic       i_wr_sel,
  input  logic [4:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_start,
  input  logic       i_new_str,
  input  logic [5:0] i_str_len,
  input  logic [3:0] i_pat_len,
  input  logic       i_valid,
  input  logic       i_match,
  input  logic [4:0] i_match_index,
  output logic       o_busy,
  output logic [7:0] o_chardata,
  output logic       o_isstring,
  output logic       o_ispattern,
  output logic       o_res_valid,
  output logic       o_res_match,
  output logic [4:0] o_res_index,
  output logic       o_res_timeout
);
  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, REPORT} state_t;

  state_t     r_state;
  logic [7:0] r_str_buf [32];
  logic [7:0] r_pat_buf [8];
  logic       r_busy;
  logic [7:0] r_chardata;
  logic       r_isstring;
  logic       r_ispattern;
  logic       r_res_valid;
  logic       r_res_match;
  logic [4:0] r_res_index;
  logic       r_res_timeout;
  logic       r_str_sent;
  logic [4:0] r_str_last;
  logic [2:0] r_pat_last;
  logic [4:0] r_sidx;
  logic [2:0] r_pidx;
  logic [7:0] r_wait;

  logic [4:0] w_str_last;
  logic [2:0] w_pat_last;
  logic [4:0] w_sidx_next;
  logic [2:0] w_pidx_next;

  // Length 32 (or 8) wraps to all-ones after the subtract, which is the last index.
  assign w_str_last  = (i_str_len == 6'd0 || i_str_len > 6'd32) ? 5'd31 : i_str_len[4:0] - 5'd1;
  assign w_pat_last  = (i_pat_len == 4'd0 || i_pat_len > 4'd8)  ? 3'd7  : i_pat_len[2:0] - 3'd1;
  assign w_sidx_next = r_sidx + 5'd1;
  assign w_pidx_next = r_pidx + 3'd1;

  always_ff @(posedge i_clk) begin
    if (i_wr_en && !r_busy) begin
      if (i_wr_sel) r_pat_buf[i_wr_addr[2:0]] <= i_wr_data;
      else          r_str_buf[i_wr_addr]      <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_chardata    <= 8'd0;
      r_isstring    <= 1'b0;
      r_ispattern   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_match   <= 1'b0;
      r_res_index   <= 5'd0;
      r_res_timeout <= 1'b0;
      r_str_sent    <= 1'b0;
      r_str_last    <= 5'd0;
      r_pat_last    <= 3'd0;
      r_sidx        <= 5'd0;
      r_pidx        <= 3'd0;
      r_wait        <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_busy     <= 1'b1;
            r_pidx     <= 3'd0;
            r_pat_last <= w_pat_last;
            if (i_new_str || !r_str_sent) begin
              r_str_sent <= 1'b1;
              r_str_last <= w_str_last;
              r_sidx     <= 5'd0;
              r_isstring <= 1'b1;
              r_chardata <= r_str_buf[5'd0];
              r_state    <= SEND_STR;
            end else begin
              r_ispattern <= 1'b1;
              r_chardata  <= r_pat_buf[3'd0];
              r_state     <= SEND_PAT;
            end
          end
        end
        SEND_STR: begin
          if (r_sidx == r_str_last) begin
            r_isstring  <= 1'b0;
            r_ispattern <= 1'b1;
            r_chardata  <= r_pat_buf[3'd0];
            r_state     <= SEND_PAT;
          end else begin
            r_sidx     <= w_sidx_next;
            r_chardata <= r_str_buf[w_sidx_next];
          end
        end
        SEND_PAT: begin
          if (r_pidx == r_pat_last) begin
            r_ispattern <= 1'b0;
            r_chardata  <= 8'd0;
            r_wait      <= 8'd0;
            r_state     <= WAIT;
          end else begin
            r_pidx     <= w_pidx_next;
            r_chardata <= r_pat_buf[w_pidx_next];
          end
        end
        WAIT: begin
          // A result arriving on the timeout cycle still wins.
          if (i_valid) begin
            r_res_match   <= i_match;
            r_res_index   <= i_match_index;
            r_res_timeout <= 1'b0;
            r_res_valid   <= 1'b1;
            r_state       <= REPORT;
          end else if (r_wait == TIMEOUT_CNT) begin
            r_res_match   <= 1'b0;
            r_res_index   <= 5'd0;
            r_res_timeout <= 1'b1;
            r_res_valid   <= 1'b1;
            r_state       <= REPORT;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        REPORT: begin
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_chardata    = r_chardata;
  assign o_isstring    = r_isstring;
  assign o_ispattern   = r_ispattern;
  assign o_res_valid   = r_res_valid;
  assign o_res_match   = r_res_match;
  assign o_res_index   = r_res_index;
  assign o_res_timeout = r_res_timeout;
endmodule
